// File: rtl/operand_dispatcher_pkg.sv
// operand_dispatcher_pkg
// Shared definitions for the operand dispatcher.
//   DefW     : default operand width (the product is 2*W bits)
//   DefDepth : default operand FIFO depth (power of two, >= 2)
//   state_t  : dispatcher FSM state encoding
package operand_dispatcher_pkg;

    localparam int unsigned DefW     = 16;
    localparam int unsigned DefDepth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StHold  = 2'd3
    } state_t;

endpackage

// File: rtl/op_fifo.sv
// op_fifo
// Circular operand FIFO. The read and write pointers wrap modulo DEPTH and a
// separate occupancy counter tells full from empty. The head entry is shown
// combinationally on rdata.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   push, wdata    : write request and data (ignored while full)
//   pop            : drop the head entry (ignored while empty)
//   rdata          : head entry
//   full, empty    : occupancy flags
//   count          : current occupancy, 0..DEPTH
module op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == FullCount);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/operand_dispatcher.sv
// operand_dispatcher
// Queues operand pairs and feeds them one at a time to an external multiplier,
// capturing each product into a result register held until the consumer
// takes it.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   in_valid/in_ready         : operand pair handshake; in_x1/in_x2 operands
//   mul_start                 : one-cycle start pulse to the multiplier
//   mul_x1/mul_x2             : registered operands, stable between starts
//   mul_out/mul_done          : product and completion (done may be a level)
//   res_valid/res_ready       : result handshake; res_data product
//   pending                   : FIFO occupancy
module operand_dispatcher
    import operand_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned W     = DefW,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x1,
    input  logic [W-1:0]   in_x2,
    output logic           mul_start,
    output logic [W-1:0]   mul_x1,
    output logic [W-1:0]   mul_x2,
    input  logic [2*W-1:0] mul_out,
    input  logic           mul_done,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic [CW-1:0]  pending
);

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_x1;
    logic [W-1:0]   r_x2;
    logic           r_res_valid;
    logic [2*W-1:0] r_res_data;
    logic           r_done_q;

    logic [2*W-1:0] w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_load;
    logic           w_capture;
    logic           w_release;
    logic           w_done_rise;

    op_fifo #(
        .DEPTH (DEPTH),
        .DW    (2 * W)
    ) u_op_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (w_pop),
        .wdata ({in_x1, in_x2}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (pending)
    );

    assign in_ready  = !w_full;
    assign mul_start = (r_state == StIssue);
    assign mul_x1    = r_x1;
    assign mul_x2    = r_x2;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    // Only a fresh rising edge completes; a level left over from the
    // previous operation (or present across reset) is ignored.
    assign w_done_rise = mul_done && !r_done_q;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Operands are latched on the way into ISSUE so they are
                // already valid during the start pulse.
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_pop        = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                if (w_done_rise) begin
                    w_capture    = 1'b1;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    w_release    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_x1        <= '0;
            r_x2        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_done_q    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done_q <= mul_done;
            if (w_load) begin
                r_x1 <= w_head[2*W-1:W];
                r_x2 <= w_head[W-1:0];
            end
            if (w_capture) begin
                r_res_data  <= mul_out;
                r_res_valid <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_dispatcher.sv
// tb_operand_dispatcher
// Directed bench for operand_dispatcher with a level-done multiplier model.
module tb_operand_dispatcher;

    typedef struct {
        logic [15:0] x1;
        logic [15:0] x2;
        logic [31:0] prod;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x1;
    logic [15:0] in_x2;
    logic        mul_start;
    logic [15:0] mul_x1;
    logic [15:0] mul_x2;
    logic [31:0] mul_out;
    logic        mul_done;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  pending;

    logic        force_done;
    logic        done_lvl;
    logic [3:0]  m_cnt;
    logic [1:0]  m_drop;
    logic [31:0] m_prod;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_starts = 0;
    int          res_cnt  = 0;
    logic [31:0] res_log [64];
    vec_t        vecs [8];
    int          base_s;
    int          base_r;
    int          pend_exp [5];

    always #5 clk = ~clk;

    assign mul_done = done_lvl | force_done;

    operand_dispatcher #(
        .DEPTH (4),
        .W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .mul_start (mul_start),
        .mul_x1    (mul_x1),
        .mul_x2    (mul_x2),
        .mul_out   (mul_out),
        .mul_done  (mul_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .pending   (pending)
    );

    // Multiplier model: product after 8 cycles, done held as a level that
    // only drops two cycles into the next operation.
    always @(posedge clk) begin
        if (!rst) begin
            m_cnt    <= 4'd0;
            m_drop   <= 2'd0;
            m_prod   <= 32'd0;
            done_lvl <= 1'b0;
            mul_out  <= 32'd0;
        end else if (mul_start) begin
            m_cnt  <= 4'd8;
            m_drop <= 2'd2;
            m_prod <= {16'd0, mul_x1} * {16'd0, mul_x2};
        end else begin
            if (m_drop == 2'd1) done_lvl <= 1'b0;
            if (m_drop != 2'd0) m_drop <= m_drop - 2'd1;
            if (m_cnt == 4'd1) begin
                done_lvl <= 1'b1;
                mul_out  <= m_prod;
            end
            if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
        end
    end

    always @(posedge clk) begin
        if (mul_start) n_starts <= n_starts + 1;
        if (res_valid && res_ready) begin
            res_log[res_cnt % 64] <= res_data;
            res_cnt <= res_cnt + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_x1    = a;
        in_x2    = b;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!res_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_res_valid", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic wait_results(input int target, input int budget);
        int k = 0;
        while (res_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("result_count", 64'(res_cnt), 64'(target));
    endtask

    initial begin
        vecs[0] = '{16'hFA10, 16'hC357, 32'hBECF2B70};
        vecs[1] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[3] = '{16'h1000, 16'h0010, 32'h00010000};
        vecs[4] = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[6] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[7] = '{16'h1234, 16'h0001, 32'h00001234};
        pend_exp = '{1, 2, 2, 3, 4};

        in_valid   = 1'b0;
        in_x1      = 16'd0;
        in_x2      = 16'd0;
        res_ready  = 1'b1;
        force_done = 1'b0;
        rst        = 1'b0;

        // Reset state and single operation with latency check.
        do_reset();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_mul_start", {63'd0, mul_start}, 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_mul_x", {32'd0, mul_x1, mul_x2}, 64'd0);
        base_s = n_starts;
        base_r = res_cnt;
        res_ready = 1'b0;
        push(vecs[0].x1, vecs[0].x2);
        check("t1_pending", 64'(pending), 64'd1);
        check("t1_no_start_yet", {63'd0, mul_start}, 64'd0);
        @(negedge clk);
        check("t1_start_t2", {63'd0, mul_start}, 64'd1);
        check("t1_mul_ops", {32'd0, mul_x1, mul_x2}, {32'd0, vecs[0].x1, vecs[0].x2});
        wait_valid(40);
        check("t1_res_data", 64'(res_data), 64'(vecs[0].prod));
        check("t1_one_start", 64'(n_starts - base_s), 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        check("t1_released", {63'd0, res_valid}, 64'd0);
        check("t1_one_result", 64'(res_cnt - base_r), 64'd1);

        // Table of operations, level done between them.
        base_s = n_starts;
        base_r = res_cnt;
        for (int i = 0; i < 8; i++) push(vecs[i].x1, vecs[i].x2);
        wait_results(base_r + 8, 400);
        repeat (20) @(negedge clk);
        check("t2_result_count", 64'(res_cnt - base_r), 64'd8);
        check("t2_start_count", 64'(n_starts - base_s), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_res_%0d", i), 64'(res_log[(base_r + i) % 64]),
                  64'(vecs[i].prod));
        end

        // Fill, backpressure, and push refused while full during ISSUE.
        do_reset();
        res_ready = 1'b0;
        base_s = n_starts;
        base_r = res_cnt;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].x1, vecs[i].x2);
            check($sformatf("t3_fill_pending_%0d", i), 64'(pending), 64'(pend_exp[i]));
        end
        check("t3_full_not_ready", {63'd0, in_ready}, 64'd0);
        wait_valid(40);
        in_valid = 1'b1;
        in_x1    = vecs[5].x1;
        in_x2    = vecs[5].x2;
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_valid", {63'd0, res_valid}, 64'd1);
            check("t3_hold_data", 64'(res_data), 64'(vecs[0].prod));
            check("t3_hold_pending", 64'(pending), 64'd4);
            @(negedge clk);
        end
        check("t3_no_new_start", 64'(n_starts - base_s), 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_idle_pending", 64'(pending), 64'd4);
        check("t3_idle_no_start", {63'd0, mul_start}, 64'd0);
        @(negedge clk);
        check("t3_issue_start", {63'd0, mul_start}, 64'd1);
        check("t3_issue_pending", 64'(pending), 64'd4);
        check("t3_issue_refused", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("t3_after_pop_pending", 64'(pending), 64'd3);
        check("t3_after_pop_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        check("t3_repush_pending", 64'(pending), 64'd4);
        in_valid = 1'b0;
        wait_results(base_r + 6, 400);
        repeat (20) @(negedge clk);
        check("t3_result_count", 64'(res_cnt - base_r), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_res_%0d", i), 64'(res_log[(base_r + i) % 64]),
                  64'(vecs[i].prod));
        end

        // Reset while waiting on the multiplier with three pairs queued.
        do_reset();
        res_ready = 1'b1;
        base_s = n_starts;
        base_r = res_cnt;
        for (int i = 1; i < 5; i++) push(vecs[i].x1, vecs[i].x2);
        check("t4_queued", 64'(pending), 64'd3);
        do_reset();
        check("t4_pending", 64'(pending), 64'd0);
        check("t4_res_valid", {63'd0, res_valid}, 64'd0);
        check("t4_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_no_start_%0d", i), {63'd0, mul_start}, 64'd0);
            @(negedge clk);
        end
        check("t4_start_count", 64'(n_starts - base_s), 64'd1);
        check("t4_no_result", 64'(res_cnt - base_r), 64'd0);

        // Done already high across reset must not count as a completion.
        force_done = 1'b1;
        do_reset();
        base_r = res_cnt;
        push(vecs[1].x1, vecs[1].x2);
        repeat (5) @(negedge clk);
        check("t5_no_early_capture", {63'd0, res_valid}, 64'd0);
        force_done = 1'b0;
        wait_valid(40);
        check("t5_res_data", 64'(res_data), 64'(vecs[1].prod));
        repeat (3) @(negedge clk);
        check("t5_one_result", 64'(res_cnt - base_r), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_dispatcher.md
OPERAND_DISPATCHER -- requirements
Module: operand_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO entries; power of two, minimum 2.
REQ-002 Parameter W, default 16: operand width; the product is 2*W bits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  FIFO can accept a pair.
REQ-007 in_x1, in_x2  in  W each  multiplicand and multiplier.
REQ-008 mul_start  out  1  start pulse to the multiplier.
REQ-009 mul_x1, mul_x2  out  W each  operands presented to the multiplier.
REQ-010 mul_out  in  2W  multiplier product.
REQ-011 mul_done  in  1  multiplier completion; may be held high as a level.
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  consumer accepts the result.
REQ-014 res_data  out  2W  captured product.
REQ-015 pending  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 A push shall occur when in_valid && in_ready; in_ready = !full.
REQ-017 The FIFO shall be circular, with read and write pointers that wrap modulo DEPTH and a separate occupancy count.
REQ-018 A push while full shall be impossible, because in_ready is low.
REQ-019 A push and a pop in the same cycle shall both take effect and leave the count unchanged; there is no same-cycle bypass, so data is issued no earlier than the cycle after it is pushed.
REQ-020 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-021 IDLE: when the FIFO is non-empty, go to ISSUE next cycle; otherwise remain in IDLE.
REQ-022 ISSUE: for exactly one cycle, mul_start = 1 and mul_x1/mul_x2 = head entry; pop the head; go to WAIT.
REQ-023 mul_x1/mul_x2 shall be registered and held stable from ISSUE until the next ISSUE.
REQ-024 WAIT: completion is the rising edge of mul_done (current high, previous-cycle registered value low); a done level held high from an earlier operation shall be ignored.
REQ-025 On completion, res_data <= mul_out, res_valid <= 1, and the FSM goes to HOLD.
REQ-026 HOLD: res_valid and res_data shall be held until res_ready is sampled high; then res_valid <= 0 and the FSM goes to IDLE.
REQ-027 If res_ready is high in the first HOLD cycle, the result is accepted in that cycle.
REQ-028 Only one operation shall be outstanding at a time; further pairs accumulate in the FIFO, which continues accepting pushes in every state.
REQ-029 Latency: push in cycle t, issue (mul_start high) in cycle t+2 when the FSM is idle.
REQ-030 Throughput: one result per (multiplier latency + 3 + consumer stall) cycles.

Reset
REQ-031 While rst = 0 at a clock edge: FSM = IDLE; FIFO pointers and count = 0; mul_start = 0; mul_x1 = mul_x2 = 0; res_valid = 0; res_data = 0; done-edge register = 0.
REQ-032 Consequences of reset: in_ready = 1 and pending = 0.
REQ-033 Reset asserted mid-operation (ISSUE, WAIT or HOLD) shall discard the in-flight result and all queued pairs.
REQ-034 After reset releases, any mul_done already high shall not be treated as a completion.

Structure
REQ-035 A shared package shall hold the FSM state encoding and the default W and DEPTH constants.
REQ-036 The FIFO shall be a single sub-module, op_fifo, with push/pop/full/empty/count ports; the FSM and result register shall stay in operand_dispatcher.

Verification
REQ-037 Single op: push 16'hFA10, 16'hC357; the model multiplier returns the exact product after 8 cycles -> exactly one mul_start pulse, and res_data = 32'hBECF2B70 with res_valid = 1.
REQ-038 Fill: push 5 pairs back-to-back with res_ready = 0 -> after the first pops, pending never exceeds 4 and in_ready drops at count 4; all 5 results emerge in push order.
REQ-039 Level done: the model holds mul_done high until the next start -> exactly one capture per operation; no double capture.
REQ-040 Backpressure: hold res_ready low for 20 cycles -> res_valid and res_data stable throughout, no new mul_start issued, and the FIFO still accepts pushes until full.
REQ-041 Reset mid-WAIT: assert rst low for 1 cycle with 3 pairs queued -> pending = 0, res_valid = 0, and no mul_start for 5 cycles after release.
REQ-042 Simultaneous push and pop at count 4 (pop in ISSUE, push with in_ready already low) -> the push is refused that cycle and accepted the next cycle; pending reads 3 then 4.
